// File: rtl/sdmac_pkg.sv
// Shared SDMAC definitions: data FIFO geometry and flush sequencer state codes.
package sdmac_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_PTRW  = $clog2(FIFO_DEPTH);

    // Flush sequencer states, kept as plain codes so legacy decode logic can match them.
    typedef logic [1:0] flush_state_t;
    localparam flush_state_t FLUSH_IDLE   = 2'd0;
    localparam flush_state_t FLUSH_COMMIT = 2'd1;
    localparam flush_state_t FLUSH_DRAIN  = 2'd2;
    localparam flush_state_t FLUSH_DONE   = 2'd3;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Strobe/status bundle between the CPU bus state machine (master) and fifo_ctrl (slave).
interface fifo_ctrl_if #(
    parameter int DEPTH = sdmac_pkg::FIFO_DEPTH,
    parameter int PTRW  = sdmac_pkg::FIFO_PTRW
);
    logic            CLRFIFO;
    logic            INCFIFO;
    logic            DECFIFO;
    logic            INCNI;
    logic            INCNO;
    logic            INCBO;
    logic            LDBO;
    logic            A1;
    logic            FLUSHFIFO;
    logic            STOPFLUSH;
    logic [PTRW-1:0] WRPTR;
    logic [PTRW-1:0] RDPTR;
    logic [1:0]      BO;
    logic [PTRW:0]   WCNT;
    logic            FIFOFULL;
    logic            FIFOEMPTY;
    logic            LASTWORD;
    logic            BOEQ3;
    logic            PARTIAL;
    logic            FLUSHDONE;
    logic            OVF;
    logic            UNF;

    modport master (
        output CLRFIFO, INCFIFO, DECFIFO, INCNI, INCNO, INCBO, LDBO, A1,
               FLUSHFIFO, STOPFLUSH,
        input  WRPTR, RDPTR, BO, WCNT, FIFOFULL, FIFOEMPTY, LASTWORD, BOEQ3,
               PARTIAL, FLUSHDONE, OVF, UNF
    );

    modport slave (
        input  CLRFIFO, INCFIFO, DECFIFO, INCNI, INCNO, INCBO, LDBO, A1,
               FLUSHFIFO, STOPFLUSH,
        output WRPTR, RDPTR, BO, WCNT, FIFOFULL, FIFOEMPTY, LASTWORD, BOEQ3,
               PARTIAL, FLUSHDONE, OVF, UNF
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping PTRW-bit FIFO pointer with synchronous clear and single-step increment.
module fifo_ptr #(
    parameter int PTRW = sdmac_pkg::FIFO_PTRW
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            clr,
    input  logic            inc,
    output logic [PTRW-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy, byte-offset and end-of-transfer flush control for the SDMAC data FIFO.
module fifo_ctrl
    import sdmac_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int PTRW  = FIFO_PTRW
) (
    input  logic       CLK,
    input  logic       RESET,
    fifo_ctrl_if.slave bus
);

    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    flush_state_t  state;
    flush_state_t  state_nxt;
    logic [PTRW:0] wcnt;
    logic [1:0]    bo;
    logic          ovf;
    logic          unf;
    logic          full;
    logic          empty;
    logic          in_commit;
    logic          commit_ok;
    logic          cnt_inc;
    logic          cnt_dec;
    logic          wr_adv;
    logic          ovf_set;
    logic          unf_set;

    assign full      = (wcnt == FULL_CNT);
    assign empty     = (wcnt == '0);
    assign in_commit = (state == FLUSH_COMMIT);
    assign commit_ok = in_commit && !full;

    // While committing, the sequencer owns the write side and external INCFIFO/INCNI are ignored.
    assign cnt_inc = in_commit ? commit_ok : bus.INCFIFO;
    assign wr_adv  = in_commit ? commit_ok : bus.INCNI;
    assign cnt_dec = bus.DECFIFO;
    assign ovf_set = in_commit ? full : (bus.INCFIFO && !cnt_dec && full);
    assign unf_set = cnt_dec && !cnt_inc && empty;

    fifo_ptr #(.PTRW(PTRW)) u_wrptr (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (bus.CLRFIFO),
        .inc   (wr_adv),
        .ptr   (bus.WRPTR)
    );

    fifo_ptr #(.PTRW(PTRW)) u_rdptr (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (bus.CLRFIFO),
        .inc   (bus.INCNO),
        .ptr   (bus.RDPTR)
    );

    always_ff @(posedge CLK) begin
        if (RESET || bus.CLRFIFO) begin
            wcnt <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            if (cnt_inc && !cnt_dec && !full) begin
                wcnt <= wcnt + 1'b1;
            end else if (cnt_dec && !cnt_inc && !empty) begin
                wcnt <= wcnt - 1'b1;
            end
            if (ovf_set) ovf <= 1'b1;
            if (unf_set) unf <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || bus.CLRFIFO) begin
            bo <= 2'd0;
        end else if (commit_ok) begin
            bo <= 2'd0;
        end else if (bus.LDBO) begin
            bo <= {bus.A1, 1'b0};
        end else if (bus.INCBO) begin
            bo <= bo + 2'd1;
        end
    end

    // NOTE: default the next state first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH_IDLE: begin
                if (bus.FLUSHFIFO) state_nxt = (bo != 2'd0) ? FLUSH_COMMIT : FLUSH_DRAIN;
            end
            FLUSH_COMMIT: begin
                state_nxt = bus.FLUSHFIFO ? FLUSH_DRAIN : FLUSH_IDLE;
            end
            FLUSH_DRAIN: begin
                if (!bus.FLUSHFIFO)                state_nxt = FLUSH_IDLE;
                else if (empty || bus.STOPFLUSH)   state_nxt = FLUSH_DONE;
            end
            FLUSH_DONE: begin
                if (!bus.FLUSHFIFO) state_nxt = FLUSH_IDLE;
            end
            default: state_nxt = FLUSH_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET || bus.CLRFIFO) begin
            state <= FLUSH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus.WCNT      = wcnt;
    assign bus.BO        = bo;
    assign bus.OVF       = ovf;
    assign bus.UNF       = unf;
    assign bus.FIFOFULL  = full;
    assign bus.FIFOEMPTY = empty;
    assign bus.LASTWORD  = (wcnt == (PTRW+1)'(1));
    assign bus.BOEQ3     = (bo == 2'd3);
    // A reset or clear landing in the COMMIT cycle cancels the commit, so no pulse either.
    assign bus.PARTIAL   = commit_ok && !RESET && !bus.CLRFIFO;
    assign bus.FLUSHDONE = (state == FLUSH_DONE);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: occupancy, pointers, byte offset and flush sequencing.
module tb_fifo_ctrl;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_errors;

    fifo_ctrl_if bus ();

    fifo_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop_strobes();
        bus.CLRFIFO = 1'b0;
        bus.INCFIFO = 1'b0;
        bus.DECFIFO = 1'b0;
        bus.INCNI   = 1'b0;
        bus.INCNO   = 1'b0;
        bus.INCBO   = 1'b0;
        bus.LDBO    = 1'b0;
    endtask

    task automatic clear_fifo();
        bus.CLRFIFO = 1'b1;
        tick();
        drop_strobes();
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            bus.INCFIFO = 1'b1;
            bus.INCNI   = 1'b1;
            tick();
        end
        drop_strobes();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RESET = 1'b1;
        drop_strobes();
        bus.A1        = 1'b0;
        bus.FLUSHFIFO = 1'b0;
        bus.STOPFLUSH = 1'b0;
        tick();
        tick();
        RESET = 1'b0;

        check("rst_wcnt",  bus.WCNT, 0);
        check("rst_empty", bus.FIFOEMPTY, 1);
        check("rst_full",  bus.FIFOFULL, 0);
        check("rst_last",  bus.LASTWORD, 0);
        check("rst_boeq3", bus.BOEQ3, 0);
        check("rst_ptrs",  {bus.WRPTR, bus.RDPTR, bus.BO}, 0);
        check("rst_flags", {bus.OVF, bus.UNF, bus.PARTIAL, bus.FLUSHDONE}, 0);

        // Fill to full; write pointer wraps back to 0.
        for (int i = 1; i <= 8; i++) begin
            push(1);
            check($sformatf("fill_wcnt%0d", i), bus.WCNT, i);
        end
        check("full_flag", bus.FIFOFULL, 1);
        check("full_empty", bus.FIFOEMPTY, 0);
        check("wrptr_wrap", bus.WRPTR, 0);
        bus.INCFIFO = 1'b1;
        tick();
        drop_strobes();
        check("ovf_wcnt", bus.WCNT, 8);
        check("ovf_set",  bus.OVF, 1);
        check("ovf_unf",  bus.UNF, 0);

        // Read pointer: 9 advances wrap to 1.
        bus.INCNO = 1'b1;
        repeat (9) tick();
        drop_strobes();
        check("rdptr_wrap", bus.RDPTR, 1);

        clear_fifo();
        check("clr_all", {bus.WCNT, bus.OVF, bus.WRPTR, bus.RDPTR}, 0);
        check("clr_empty", bus.FIFOEMPTY, 1);

        // Simultaneous inc/dec and underflow.
        bus.INCFIFO = 1'b1;
        tick();
        drop_strobes();
        bus.INCFIFO = 1'b1;
        bus.DECFIFO = 1'b1;
        tick();
        drop_strobes();
        check("incdec_wcnt", bus.WCNT, 1);
        check("incdec_last", bus.LASTWORD, 1);
        check("incdec_flags", {bus.OVF, bus.UNF}, 0);
        bus.DECFIFO = 1'b1;
        tick();
        drop_strobes();
        check("dec_to_empty", bus.WCNT, 0);
        bus.INCFIFO = 1'b1;
        bus.DECFIFO = 1'b1;
        tick();
        drop_strobes();
        check("incdec_empty_wcnt", bus.WCNT, 0);
        check("incdec_empty_unf", bus.UNF, 0);
        bus.DECFIFO = 1'b1;
        tick();
        drop_strobes();
        check("unf_set",  bus.UNF, 1);
        check("unf_wcnt", bus.WCNT, 0);

        // Byte offset load, increment, wrap, LDBO priority.
        clear_fifo();
        bus.LDBO = 1'b1;
        bus.A1   = 1'b1;
        tick();
        drop_strobes();
        check("ldbo_bo", bus.BO, 2);
        bus.INCBO = 1'b1;
        tick();
        drop_strobes();
        check("incbo_bo3", bus.BO, 3);
        check("boeq3", bus.BOEQ3, 1);
        bus.INCBO = 1'b1;
        tick();
        drop_strobes();
        check("incbo_wrap", bus.BO, 0);
        check("boeq3_clr", bus.BOEQ3, 0);
        bus.INCBO = 1'b1;
        tick();
        bus.LDBO = 1'b1;
        bus.A1   = 1'b0;
        tick();
        drop_strobes();
        check("ldbo_priority", bus.BO, 0);

        // Flush with a partial longword: commit, drain, done.
        clear_fifo();
        push(3);
        bus.LDBO = 1'b1;
        bus.A1   = 1'b1;
        tick();
        drop_strobes();
        bus.FLUSHFIFO = 1'b1;
        tick();
        check("commit_partial", bus.PARTIAL, 1);
        check("commit_wcnt", bus.WCNT, 3);
        tick();
        check("partial_one_cycle", bus.PARTIAL, 0);
        check("commit_wcnt_after", bus.WCNT, 4);
        check("commit_bo", bus.BO, 0);
        check("commit_wrptr", bus.WRPTR, 4);
        bus.DECFIFO = 1'b1;
        repeat (4) tick();
        drop_strobes();
        check("drain_wcnt", bus.WCNT, 0);
        check("drain_not_done", bus.FLUSHDONE, 0);
        tick();
        check("flushdone", bus.FLUSHDONE, 1);
        tick();
        check("flushdone_hold", bus.FLUSHDONE, 1);
        bus.FLUSHFIFO = 1'b0;
        tick();
        check("flushdone_drop", bus.FLUSHDONE, 0);

        // Flush on an empty FIFO with BO==0: done two cycles after request.
        bus.FLUSHFIFO = 1'b1;
        tick();
        check("empty_flush_c1", {bus.PARTIAL, bus.FLUSHDONE}, 0);
        tick();
        check("empty_flush_c2", bus.FLUSHDONE, 1);
        bus.FLUSHFIFO = 1'b0;
        tick();

        // STOPFLUSH while draining a non-empty FIFO.
        push(5);
        bus.FLUSHFIFO = 1'b1;
        tick();
        check("stop_drain", {bus.PARTIAL, bus.FLUSHDONE}, 0);
        bus.STOPFLUSH = 1'b1;
        tick();
        bus.STOPFLUSH = 1'b0;
        check("stop_done", bus.FLUSHDONE, 1);
        check("stop_wcnt", bus.WCNT, 5);
        bus.FLUSHFIFO = 1'b0;
        tick();

        // FLUSHFIFO dropped in DRAIN: back to IDLE, no FLUSHDONE.
        bus.FLUSHFIFO = 1'b1;
        tick();
        bus.FLUSHFIFO = 1'b0;
        tick();
        check("abort_no_done", bus.FLUSHDONE, 0);
        tick();
        check("abort_idle", bus.FLUSHDONE, 0);

        // RESET landing in the COMMIT cycle.
        clear_fifo();
        push(6);
        bus.LDBO = 1'b1;
        bus.A1   = 1'b1;
        tick();
        drop_strobes();
        bus.FLUSHFIFO = 1'b1;
        tick();
        check("rc_partial", bus.PARTIAL, 1);
        RESET = 1'b1;
        bus.FLUSHFIFO = 1'b0;
        tick();
        RESET = 1'b0;
        check("rc_wcnt", bus.WCNT, 0);
        check("rc_regs", {bus.BO, bus.WRPTR, bus.RDPTR, bus.OVF, bus.UNF}, 0);
        check("rc_status", {bus.FIFOEMPTY, bus.FIFOFULL, bus.LASTWORD, bus.BOEQ3}, 4'b1000);
        check("rc_flush", {bus.PARTIAL, bus.FLUSHDONE}, 0);
        tick();
        check("rc_idle", {bus.PARTIAL, bus.FLUSHDONE, bus.WCNT}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer, occupancy and flush controller for the 8-longword SDMAC data FIFO. It sits between the SCSI byte-side datapath and the CPU bus state machine. It consumes that state machine's INCFIFO/DECFIFO/INCNI/INCNO strobes and the byte-side INCBO strobe. It produces the FIFOFULL, FIFOEMPTY, LASTWORD and BOEQ3 status the state machine branches on, and sequences the end-of-transfer flush of a partially filled longword.

## Interface
- DEPTH, 8: FIFO depth in longwords; power of two, 2..16.
- PTRW, 3: pointer width, log2(DEPTH).
- CLK  in  1  sole clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLRFIFO  in  1  synchronous clear of pointers, count, byte offset and error flags.
- INCFIFO  in  1  one longword entered storage (count +1).
- DECFIFO  in  1  one longword left storage (count -1).
- INCNI  in  1  advance write (next-in) pointer.
- INCNO  in  1  advance read (next-out) pointer.
- INCBO  in  1  advance byte offset within the current input longword.
- LDBO  in  1  load byte offset from {A1,1'b0} (start alignment).
- A1  in  1  address bit 1 of transfer start.
- FLUSHFIFO  in  1  level request to flush at end of transfer.
- STOPFLUSH  in  1  CPU side aborts draining.
- WRPTR  out  PTRW  write pointer.
- RDPTR  out  PTRW  read pointer.
- BO  out  2  byte offset.
- WCNT  out  PTRW+1  longwords held, 0..DEPTH.
- FIFOFULL  out  1  WCNT==DEPTH.
- FIFOEMPTY  out  1  WCNT==0.
- LASTWORD  out  1  WCNT==1.
- BOEQ3  out  1  BO==3.
- PARTIAL  out  1  one-cycle pulse, partial longword committed by flush.
- FLUSHDONE  out  1  flush complete; held until FLUSHFIFO falls.
- OVF  out  1  sticky, INCFIFO while full.
- UNF  out  1  sticky, DECFIFO while empty.

## Operation
- Reset/CLRFIFO: WRPTR=RDPTR=0, WCNT=0, BO=0, OVF=UNF=0, PARTIAL=FLUSHDONE=0, state IDLE. Status outputs then read FIFOEMPTY=1, FIFOFULL=0, LASTWORD=0, BOEQ3=0. Priority: RESET > CLRFIFO > all strobes.
- Pointers are modulo DEPTH and wrap DEPTH-1 -> 0 silently. INCNI and INCNO are independent; the block does not cross-check them against WCNT.
- WCNT: INCFIFO&DECFIFO in the same cycle leaves WCNT unchanged and sets no flags, even when full or empty. INCFIFO alone at full leaves WCNT unchanged and sets OVF. DECFIFO alone at empty leaves WCNT unchanged and sets UNF.
- BO: LDBO wins over INCBO. INCBO at BO==3 wraps to 0; the byte datapath issues INCFIFO/INCNI itself on that wrap.
- Flush FSM states IDLE, COMMIT, DRAIN, DONE:
  - IDLE: on FLUSHFIFO=1, go to COMMIT if BO!=0, else go to DRAIN.
  - COMMIT (one cycle): internally apply WCNT+1 and WRPTR+1, set BO=0, and pulse PARTIAL. If full, apply nothing and set OVF. External INCFIFO/INCNI in this cycle are ignored. Then go to DRAIN.
  - DRAIN: go to DONE when FIFOEMPTY or STOPFLUSH.
  - DONE: FLUSHDONE=1; go to IDLE when FLUSHFIFO=0.
  - FLUSHFIFO dropping in COMMIT or DRAIN returns the FSM to IDLE without asserting FLUSHDONE.

## Timing
- All registered state updates one cycle after the strobe edge. Status flags are decoded combinationally from the registered WCNT/BO, so they are valid the cycle after the update.
- Strobes are single-cycle qualified; a strobe held N cycles acts N times.
- PARTIAL is exactly one cycle wide, in the COMMIT cycle. FLUSHDONE rises at the earliest 2 cycles after FLUSHFIFO when BO==0, and 3 cycles after when BO!=0, provided the FIFO is already empty.

## Structure
- Shared sdmac_pkg holds FIFO_DEPTH, FIFO_PTRW and the flush-state enumeration (IDLE/COMMIT/DRAIN/DONE).
- One sub-module, fifo_ptr: a wrapping PTRW-bit counter with sync clear and increment, instantiated for WRPTR and RDPTR.

## Test plan
- Reset then 8 INCFIFO+INCNI -> WCNT=8, FIFOFULL=1, WRPTR wrapped to 0. A 9th INCFIFO -> WCNT stays 8, OVF=1.
- From WCNT=1, simultaneous INCFIFO+DECFIFO -> WCNT=1, LASTWORD=1, no OVF/UNF. A DECFIFO at empty -> UNF=1, WCNT=0.
- LDBO with A1=1 -> BO=2. One INCBO -> BO=3, BOEQ3=1. Another INCBO -> BO=0.
- BO=2, WCNT=3, assert FLUSHFIFO -> PARTIAL pulse next cycle, WCNT=4, BO=0. After 4 DECFIFO, FLUSHDONE=1 until FLUSHFIFO=0.
- In DRAIN with WCNT=5, STOPFLUSH -> FLUSHDONE next cycle, WCNT unchanged.
- RESET asserted mid-COMMIT with WCNT=6 -> next cycle all outputs at reset values, FSM IDLE, no PARTIAL.
